twiddle_multiplier_pipe: RTL and testbench

- Pipelined, parametrised multi-lane complex multiplier for the FFT butterfly datapath. It multiplies LANES complex samples by LANES complex twiddles per beat.
- Generalises the fixed 8-lane, 16-bit multiplier in four ways: a valid/ready handshake with backpressure, fixed-point rounding and saturation, a conjugate (IFFT) mode and a bypass mode.
- Sits between the twiddle ROM/address stage and the butterfly adders. Twiddles arrive on ports; this block contains no LUT.

---
 rtl/twiddle_multiplier_pipe_if.sv | 37 +++
 rtl/twiddle_multiplier_pipe.sv | 199 +++++++++++++++++++
 tb/tb_twiddle_multiplier_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_multiplier_pipe_if.sv
// Beat-level handshake and lane data bundle for the twiddle multiplier.
// The master side feeds samples/twiddles and consumes results; the slave side is the multiplier.
`timescale 1ns / 1ps

interface twiddle_multiplier_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic                         conj;
  logic                         bypass;
  logic [LANES-1:0][DATA_W-1:0] x_re;
  logic [LANES-1:0][DATA_W-1:0] x_im;
  logic [LANES-1:0][DATA_W-1:0] tw_re;
  logic [LANES-1:0][DATA_W-1:0] tw_im;

  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic [LANES-1:0][DATA_W-1:0] y_re;
  logic [LANES-1:0][DATA_W-1:0] y_im;

  logic                         sat_sticky;
  logic                         sat_clear;

  modport master (
    output in_valid, in_last, conj, bypass, x_re, x_im, tw_re, tw_im, out_ready, sat_clear,
    input  in_ready, out_valid, out_last, y_re, y_im, sat_sticky
  );

  modport slave (
    input  in_valid, in_last, conj, bypass, x_re, x_im, tw_re, tw_im, out_ready, sat_clear,
    output in_ready, out_valid, out_last, y_re, y_im, sat_sticky
  );
endinterface

// File: rtl/twiddle_multiplier_pipe.sv
// Three-stage multi-lane complex multiplier (sample x twiddle) with rounding, saturation,
// conjugate and bypass modes. All stages advance together under a single output-driven stall.
`timescale 1ns / 1ps

module twiddle_multiplier_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 15,
  parameter int unsigned LANES  = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  twiddle_multiplier_pipe_if.slave bus
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned SumW  = ProdW + 1;

  localparam logic signed [SumW-1:0] SatMax = {{(SumW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = {{(SumW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SumW-1:0] RndC   =
    {{(SumW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;
  typedef logic [LANES-1:0][ProdW-1:0]  prod_vec_t;

  function automatic logic signed [ProdW-1:0] sext_data(input logic [DATA_W-1:0] v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [SumW-1:0] sext_prod(input logic [ProdW-1:0] v);
    return {v[ProdW-1], v};
  endfunction

  // Returns {saturated, value}; rounding is half toward +inf.
  function automatic logic [DATA_W:0] round_sat(input logic signed [SumW-1:0] v);
    logic signed [SumW-1:0] r;
    r = (v + RndC) >>> FRAC_W;
    if (r > SatMax) begin
      return {1'b1, SatMax[DATA_W-1:0]};
    end else if (r < SatMin) begin
      return {1'b1, SatMin[DATA_W-1:0]};
    end else begin
      return {1'b0, r[DATA_W-1:0]};
    end
  endfunction

  logic adv;

  // Stage 1: registered inputs and mode bits
  logic      s1_valid_q, s1_last_q, s1_conj_q, s1_bypass_q;
  lane_vec_t s1_x_re_q, s1_x_im_q, s1_tw_re_q, s1_tw_im_q;

  // Stage 2: full-width partial products
  logic      s2_valid_q, s2_last_q, s2_conj_q, s2_bypass_q;
  lane_vec_t s2_x_re_q, s2_x_im_q;
  prod_vec_t p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  prod_vec_t p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  // Stage 3: outputs
  logic      out_valid_q, out_last_q;
  lane_vec_t y_re_d, y_im_d, y_re_q, y_im_q;
  logic      sat_any;
  logic      sat_sticky_d, sat_sticky_q;

  logic signed [SumW-1:0] rr, ii, ri, ir, re_sum, im_sum;
  logic        [DATA_W:0] re_rs, im_rs;

  assign adv = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_conj_q   <= 1'b0;
      s1_bypass_q <= 1'b0;
      s1_x_re_q   <= '0;
      s1_x_im_q   <= '0;
      s1_tw_re_q  <= '0;
      s1_tw_im_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s1_last_q   <= bus.in_last;
      s1_conj_q   <= bus.conj;
      s1_bypass_q <= bus.bypass;
      s1_x_re_q   <= bus.x_re;
      s1_x_im_q   <= bus.x_im;
      s1_tw_re_q  <= bus.tw_re;
      s1_tw_im_q  <= bus.tw_im;
    end
  end

  always_comb begin
    p_rr_d = '0;
    p_ii_d = '0;
    p_ri_d = '0;
    p_ir_d = '0;
    for (int l = 0; l < LANES; l++) begin
      p_rr_d[l] = sext_data(s1_x_re_q[l]) * sext_data(s1_tw_re_q[l]);
      p_ii_d[l] = sext_data(s1_x_im_q[l]) * sext_data(s1_tw_im_q[l]);
      p_ri_d[l] = sext_data(s1_x_re_q[l]) * sext_data(s1_tw_im_q[l]);
      p_ir_d[l] = sext_data(s1_x_im_q[l]) * sext_data(s1_tw_re_q[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_conj_q   <= 1'b0;
      s2_bypass_q <= 1'b0;
      s2_x_re_q   <= '0;
      s2_x_im_q   <= '0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
    end else if (adv) begin
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_conj_q   <= s1_conj_q;
      s2_bypass_q <= s1_bypass_q;
      s2_x_re_q   <= s1_x_re_q;
      s2_x_im_q   <= s1_x_im_q;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
    end
  end

  // Combine one bit wider than the products so the (-1)*(-1) corner cannot wrap.
  always_comb begin
    y_re_d  = '0;
    y_im_d  = '0;
    sat_any = 1'b0;
    rr      = '0;
    ii      = '0;
    ri      = '0;
    ir      = '0;
    re_sum  = '0;
    im_sum  = '0;
    re_rs   = '0;
    im_rs   = '0;
    for (int l = 0; l < LANES; l++) begin
      rr = sext_prod(p_rr_q[l]);
      ii = sext_prod(p_ii_q[l]);
      ri = sext_prod(p_ri_q[l]);
      ir = sext_prod(p_ir_q[l]);
      if (s2_conj_q) begin
        re_sum = rr + ii;
        im_sum = ir - ri;
      end else begin
        re_sum = rr - ii;
        im_sum = ri + ir;
      end
      re_rs = round_sat(re_sum);
      im_rs = round_sat(im_sum);
      if (s2_bypass_q) begin
        y_re_d[l] = s2_x_re_q[l];
        y_im_d[l] = s2_x_im_q[l];
      end else begin
        y_re_d[l] = re_rs[DATA_W-1:0];
        y_im_d[l] = im_rs[DATA_W-1:0];
        sat_any   = sat_any | re_rs[DATA_W] | im_rs[DATA_W];
      end
    end
  end

  // A saturating beat entering the output register wins over a simultaneous clear.
  assign sat_sticky_d = (sat_sticky_q & ~bus.sat_clear) | (adv & s2_valid_q & sat_any);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      y_re_q       <= '0;
      y_im_q       <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      if (adv) begin
        out_valid_q <= s2_valid_q;
        out_last_q  <= s2_valid_q & s2_last_q;
        if (s2_valid_q) begin
          y_re_q <= y_re_d;
          y_im_q <= y_im_d;
        end
      end
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign bus.in_ready   = adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.y_re       = y_re_q;
  assign bus.y_im       = y_im_q;
  assign bus.sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_twiddle_multiplier_pipe.sv
// Scoreboard bench for twiddle_multiplier_pipe: expected beats are queued on acceptance
// and compared when the block presents them.
`timescale 1ns / 1ps

module tb_twiddle_multiplier_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 15;
  localparam int unsigned LN = 8;

  typedef logic [LN-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t xr, xi, tr, ti;
    logic conj, bypass, last;
  } stim_t;
  typedef struct packed {
    vec_t re, im;
    logic last;
    logic sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  twiddle_multiplier_pipe_if #(.DATA_W(DW), .LANES(LN)) bus ();

  twiddle_multiplier_pipe #(.DATA_W(DW), .FRAC_W(FW), .LANES(LN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Floor-division reference for round-half-up then clamp; returns {saturated, value}.
  function automatic logic [DW:0] rnd_sat(input longint v);
    longint t, r, d;
    d = longint'(1) << FW;
    t = v + (d / 2);
    r = t / d;
    if ((t < 0) && ((t % d) != 0)) r = r - 1;
    if (r > 32767) return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    longint ar, ai, br, bi;
    logic [DW:0] qr, qi;
    e = '0;
    e.last = s.last;
    for (int l = 0; l < LN; l++) begin
      if (s.bypass) begin
        e.re[l] = s.xr[l];
        e.im[l] = s.xi[l];
      end else begin
        ar = longint'($signed(s.xr[l]));
        ai = longint'($signed(s.xi[l]));
        br = longint'($signed(s.tr[l]));
        bi = longint'($signed(s.ti[l]));
        if (s.conj) begin
          qr = rnd_sat(ar * br + ai * bi);
          qi = rnd_sat(ai * br - ar * bi);
        end else begin
          qr = rnd_sat(ar * br - ai * bi);
          qi = rnd_sat(ar * bi + ai * br);
        end
        e.re[l] = qr[DW-1:0];
        e.im[l] = qi[DW-1:0];
        e.sat   = e.sat | qr[DW] | qi[DW];
      end
    end
    return e;
  endfunction

  function automatic stim_t rand_stim(input logic conj, input logic byp, input logic last);
    stim_t s;
    for (int l = 0; l < LN; l++) begin
      s.xr[l] = 16'($urandom);
      s.xi[l] = 16'($urandom);
      s.tr[l] = 16'($urandom);
      s.ti[l] = 16'($urandom);
    end
    s.conj   = conj;
    s.bypass = byp;
    s.last   = last;
    return s;
  endfunction

  // Drives one cycle of stimulus and samples outputs mid-cycle; performs no checks.
  task automatic cycle(input logic v, input stim_t s, input logic ordy,
                       output logic acc, output logic got, output logic ov, output exp_t obs);
    @(negedge clk);
    bus.in_valid  = v;
    bus.x_re      = s.xr;
    bus.x_im      = s.xi;
    bus.tw_re     = s.tr;
    bus.tw_im     = s.ti;
    bus.conj      = s.conj;
    bus.bypass    = s.bypass;
    bus.in_last   = s.last;
    bus.out_ready = ordy;
    #1;
    acc      = v && bus.in_ready;
    ov       = bus.out_valid;
    got      = bus.out_valid && ordy;
    obs.re   = bus.y_re;
    obs.im   = bus.y_im;
    obs.last = bus.out_last;
    obs.sat  = bus.sat_sticky;
    if (acc) sb.push_back(model(s));
  endtask

  // Sends a single beat into an idle pipe and reports cycles until it is presented.
  task automatic send_one(input stim_t s, output int lat, output exp_t obs);
    logic acc, got, ov;
    exp_t o;
    lat = -1;
    obs = '0;
    cycle(1'b1, s, 1'b1, acc, got, ov, o);
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      cycle(1'b0, s, 1'b1, acc, got, ov, o);
      if (got) begin
        lat = k;
        obs = o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++; if (bus.out_last !== 1'b0) begin
      bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last);
    end
    total++; if (bus.y_re !== '0 || bus.y_im !== '0) begin
      bad++; $display("FAIL reset_y: got re=%h im=%h want 0", bus.y_re, bus.y_im);
    end
    total++; if (bus.sat_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_sat_sticky: got %b want 0", bus.sat_sticky);
    end
    total++; if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    stim_t s;
    exp_t obs, e;
    int lat;
    vec_t wre, wim;
    s = '0;
    for (int l = 0; l < LN; l++) begin
      s.xr[l] = 16'h4000;
      s.ti[l] = 16'h7fff;
      wre[l]  = 16'h0000;
      wim[l]  = 16'h4000;
    end
    send_one(s, lat, obs);
    total++; if (lat != 3) begin
      bad++; $display("FAIL basic_latency: got %0d want 3", lat);
    end
    total++; if (obs.re !== wre || obs.im !== wim) begin
      bad++; $display("FAIL basic_value: got re=%h im=%h want re=%h im=%h",
                      obs.re, obs.im, wre, wim);
    end
    total++; if (obs.sat !== 1'b0) begin
      bad++; $display("FAIL basic_sat_sticky: got %b want 0", obs.sat);
    end
    total++; if (sb.size() == 0) begin
      bad++; $display("FAIL basic_scoreboard: got empty queue want 1 entry");
    end else begin
      e = sb.pop_front();
      if ({obs.re, obs.im, obs.last} !== {e.re, e.im, e.last}) begin
        bad++; $display("FAIL basic_scoreboard: got re=%h im=%h want re=%h im=%h",
                        obs.re, obs.im, e.re, e.im);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    exp_t obs, e;
    int lat;
    vec_t wre, wim;
    for (int l = 0; l < LN; l++) begin
      s.xr[l] = 16'h8000;
      s.xi[l] = 16'h8000;
      s.tr[l] = 16'h8000;
      s.ti[l] = 16'h8000;
      wre[l]  = 16'h0000;
      wim[l]  = 16'h7fff;
    end
    s.conj = 1'b0;
    s.bypass = 1'b0;
    s.last = 1'b0;
    send_one(s, lat, obs);
    total++; if (lat != 3 || obs.re !== wre || obs.im !== wim) begin
      bad++; $display("FAIL sat_value: got lat=%0d re=%h im=%h want lat=3 re=%h im=%h",
                      lat, obs.re, obs.im, wre, wim);
    end
    total++; if (obs.sat !== 1'b1) begin
      bad++; $display("FAIL sat_sticky_set: got %b want 1", obs.sat);
    end
    total++; if (sb.size() == 0) begin
      bad++; $display("FAIL sat_scoreboard: got empty queue want 1 entry");
    end else begin
      e = sb.pop_front();
      if ({obs.re, obs.im} !== {e.re, e.im}) begin
        bad++; $display("FAIL sat_scoreboard: got re=%h im=%h want re=%h im=%h",
                        obs.re, obs.im, e.re, e.im);
      end
    end
    @(negedge clk); #1;
    total++; if (bus.sat_sticky !== 1'b1) begin
      bad++; $display("FAIL sat_sticky_hold: got %b want 1", bus.sat_sticky);
    end
    @(negedge clk);
    bus.sat_clear = 1'b1;
    @(negedge clk);
    bus.sat_clear = 1'b0;
    #1;
    total++; if (bus.sat_sticky !== 1'b0) begin
      bad++; $display("FAIL sat_clear: got %b want 0", bus.sat_sticky);
    end
    // Clear held high while another saturating beat lands: the set must win.
    bus.sat_clear = 1'b1;
    send_one(s, lat, obs);
    total++; if (obs.sat !== 1'b1) begin
      bad++; $display("FAIL sat_set_wins: got %b want 1", obs.sat);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    bus.sat_clear = 1'b0;
    #1;
    total++; if (bus.sat_sticky !== 1'b0) begin
      bad++; $display("FAIL sat_clear_after_set: got %b want 0", bus.sat_sticky);
    end
  endtask

  task automatic test_conj_round();
    stim_t s;
    exp_t obs, e;
    int lat;
    vec_t wre, wim;
    for (int l = 0; l < LN; l++) begin
      s.xr[l] = 16'h0001;
      s.xi[l] = 16'hffff;
      s.tr[l] = 16'h4000;
      s.ti[l] = 16'h4000;
      wre[l]  = 16'h0000;
      wim[l]  = 16'hffff;
    end
    s.conj = 1'b1;
    s.bypass = 1'b0;
    s.last = 1'b1;
    send_one(s, lat, obs);
    total++; if (lat != 3 || obs.re !== wre || obs.im !== wim) begin
      bad++; $display("FAIL conj_round: got lat=%0d re=%h im=%h want lat=3 re=%h im=%h",
                      lat, obs.re, obs.im, wre, wim);
    end
    total++; if (obs.last !== 1'b1 || obs.sat !== 1'b0) begin
      bad++; $display("FAIL conj_flags: got last=%b sat=%b want last=1 sat=0",
                      obs.last, obs.sat);
    end
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_backpressure();
    stim_t st[10];
    exp_t obs, pobs, e;
    logic acc, got, ov, ordy, pstall;
    int sent, rcv, idx;
    for (int i = 0; i < 10; i++) st[i] = rand_stim(1'($urandom_range(0, 1)), 1'b0, i == 9);
    sent = 0;
    rcv = 0;
    pstall = 1'b0;
    pobs = '0;
    for (int c = 0; c < 300 && rcv < 10; c++) begin
      ordy = (c % 3 == 0);
      idx = (sent < 10) ? sent : 9;
      cycle(sent < 10, st[idx], ordy, acc, got, ov, obs);
      if (pstall) begin
        total++;
        if (!ov || {obs.re, obs.im, obs.last} !== {pobs.re, pobs.im, pobs.last}) begin
          bad++; $display("FAIL bp_stall_hold: got v=%b re=%h last=%b want v=1 re=%h last=%b",
                          ov, obs.re, obs.last, pobs.re, pobs.last);
        end
      end
      if (acc) sent++;
      if (got) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_beat: got unexpected beat %0d want none", rcv);
        end else begin
          e = sb.pop_front();
          if ({obs.re, obs.im, obs.last} !== {e.re, e.im, e.last}) begin
            bad++; $display("FAIL bp_beat%0d: got re=%h im=%h last=%b want re=%h im=%h last=%b",
                            rcv, obs.re, obs.im, obs.last, e.re, e.im, e.last);
          end
        end
        rcv++;
      end
      pstall = ov && !ordy;
      pobs = obs;
    end
    total++; if (rcv != 10 || sb.size() != 0) begin
      bad++; $display("FAIL bp_count: got rcv=%0d pending=%0d want rcv=10 pending=0",
                      rcv, sb.size());
    end
  endtask

  task automatic test_bypass_interleave();
    stim_t st[8];
    exp_t obs, e;
    logic acc, got, ov;
    int rcv, idx;
    for (int i = 0; i < 8; i++) st[i] = rand_stim(1'($urandom_range(0, 1)), i % 2 == 0, 1'b0);
    rcv = 0;
    for (int k = 0; k < 12; k++) begin
      idx = (k < 8) ? k : 7;
      cycle(k < 8, st[idx], 1'b1, acc, got, ov, obs);
      if (got) begin
        total++;
        if (rcv != k - 3 || sb.size() == 0) begin
          bad++; $display("FAIL byp_latency: got beat %0d at cycle %0d want cycle %0d",
                          rcv, k, rcv + 3);
        end else begin
          e = sb.pop_front();
          if ({obs.re, obs.im} !== {e.re, e.im}) begin
            bad++; $display("FAIL byp_beat%0d: got re=%h im=%h want re=%h im=%h",
                            rcv, obs.re, obs.im, e.re, e.im);
          end else if (st[rcv].bypass && {obs.re, obs.im} !== {st[rcv].xr, st[rcv].xi}) begin
            bad++; $display("FAIL byp_raw%0d: got re=%h want re=%h", rcv, obs.re, st[rcv].xr);
          end
        end
        if (rcv < 7) rcv++;
        else rcv = 8;
      end
    end
    total++; if (rcv != 8) begin
      bad++; $display("FAIL byp_count: got %0d want 8", rcv);
    end
  endtask

  task automatic test_reset_midstream();
    stim_t s;
    exp_t obs, e;
    logic acc, got, ov;
    int stale, lat;
    for (int k = 0; k < 3; k++) begin
      s = rand_stim(1'b0, 1'b0, 1'b1);
      cycle(1'b1, s, 1'b1, acc, got, ov, obs);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      bad++; $display("FAIL midrst_out: got v=%b last=%b want v=0 last=0",
                      bus.out_valid, bus.out_last);
    end
    sb.delete();
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, s, 1'b1, acc, got, ov, obs);
      if (ov) stale++;
    end
    total++; if (stale != 0) begin
      bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale);
    end
    s = rand_stim(1'b1, 1'b0, 1'b0);
    send_one(s, lat, obs);
    total++; if (lat != 3 || sb.size() != 1) begin
      bad++; $display("FAIL midrst_recover: got lat=%0d pending=%0d want lat=3 pending=1",
                      lat, sb.size());
    end else begin
      e = sb.pop_front();
      total++; if ({obs.re, obs.im} !== {e.re, e.im}) begin
        bad++; $display("FAIL midrst_value: got re=%h want re=%h", obs.re, e.re);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.conj      = 1'b0;
    bus.bypass    = 1'b0;
    bus.x_re      = '0;
    bus.x_im      = '0;
    bus.tw_re     = '0;
    bus.tw_im     = '0;
    bus.out_ready = 1'b1;
    bus.sat_clear = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_conj_round();
    test_backpressure();
    test_bypass_interleave();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want completion (total=%0d bad=%0d)",
             total, bad);
    $fatal(1, "time limit reached");
  end

endmodule
